rsa_mod_exp_engine: RTL and testbench
=====================================

# rsa_mod_exp_engine

Parametrised, handshaked modular-exponentiation engine computing result = base^exp mod n for RSA encrypt/decrypt. It generalises the fixed-width exponentiation path behind `control` in several ways:
- independent modulus and exponent widths;
- valid/ready handshakes instead of reset-pulse sequencing;
- an abort input;
- an optional constant-time mode.

It sits between the key/message front-end and the message output register.

## Interface
- WIDTH, 256, modulus/base/result width in bits (≥ 4)
- EXP_WIDTH, 256, exponent width in bits (≥ 1)
- CONST_TIME, 0, 1 = perform (and discard) the multiply on every exponent bit
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset; one clock, no other clock domains
- in_valid  in  1  operand set valid
- in_ready  out  1  engine can accept operands (high only in IDLE)
- base  in  WIDTH  message/ciphertext; any value, reduced internally
- exp  in  EXP_WIDTH  exponent (e or d)
- n  in  WIDTH  modulus
- abort  in  1  cancel current operation
- out_valid  out  1  result/err valid; held until accepted
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  base^exp mod n
- err  out  1  set with out_valid when n == 0
- busy  out  1  high in any state other than IDLE and DONE

## Operation
- States: IDLE, REDUCE, SQUARE, MULT, DONE.
- IDLE:
  - in_valid && in_ready captures base, exp and n.
  - If n == 0, go to DONE with err = 1 and result = 0.
  - Otherwise go to REDUCE, with acc = (n == 1) ? 0 : 1 and bit index = EXP_WIDTH-1.
- REDUCE: base_r = modmul(base, 1), which gives base mod n. Then go to SQUARE.
- SQUARE: acc = modmul(acc, acc). Then:
  - if exp[idx] = 1, or CONST_TIME = 1, go to MULT;
  - otherwise advance the index.
- MULT: tmp = modmul(base_r, acc). acc takes tmp only if exp[idx] = 1; in CONST_TIME mode with a zero bit, tmp is discarded. Then advance the index.
- Advance:
  - if idx == 0, go to DONE with result = acc;
  - otherwise decrement idx and go to SQUARE.
- DONE:
  - out_valid = 1; result and err are stable.
  - out_ready returns to IDLE on the same edge.
- modmul(a, b) is interleaved MSB-first Blakley multiplication, one bit of a per cycle:
  - each iteration computes acc2 = 2·acc2 + (a_bit ? b : 0);
  - then at most two conditional subtractions of n keep acc2 < n;
  - requires b < n; a is unrestricted.
- Internal datapath width is WIDTH+2 bits. Intermediates never exceed 3n.
- Abort:
  - in REDUCE, SQUARE or MULT, the next edge goes to IDLE; no out_valid is produced and the multiplier is cleared.
  - in IDLE or DONE, abort is ignored.
- A reset mid-operation returns everything to reset values immediately.

## Timing
- Reset values: in_ready = 1 once reset_n is high; out_valid, result, err and busy are 0.
- Each modmul occupies M = WIDTH+2 cycles: 1 launch cycle, WIDTH iterations, 1 capture cycle.
- Latency from the accept edge to out_valid high is M·(1 + EXP_WIDTH + k):
  - k = popcount(exp), or EXP_WIDTH when CONST_TIME = 1;
  - for n == 0, latency is 1 cycle.
- If out_ready is already high when out_valid rises, the result is consumed after 1 cycle in DONE.
- in_ready rises on the edge entering IDLE.
- A new operand set can be accepted one cycle after result acceptance.
- in_valid while busy is ignored; there is no queuing.
- abort and out_ready in the same cycle: DONE takes priority, because abort is ignored in DONE.

## Structure
- rsa_pkg holds:
  - state encoding localparams (IDLE = 0, REDUCE = 1, SQUARE = 2, MULT = 3, DONE = 4);
  - default WIDTH/EXP_WIDTH constants;
  - the datapath-width helper (WIDTH+2).
- Sub-module rsa_mod_mul_serial (parameter WIDTH):
  - inputs: start, a, b, n, clear;
  - outputs: done (1-cycle pulse), p.
  - It is instantiated once and shared by REDUCE, SQUARE and MULT.

## Test plan
- WIDTH = 16, EXP_WIDTH = 16: base = 4, exp = 13, n = 497 → result = 445 after 18·(1+16+3) = 360 cycles; err = 0.
- Textbook RSA, n = 3233:
  - encrypt base = 65, exp = 17 → 2790 after 18·19 = 342 cycles;
  - then decrypt base = 2790, exp = 2753 → 65.
- CONST_TIME = 1, same encrypt → 2790 after 18·33 = 594 cycles, regardless of exp.
- Edge values:
  - n = 0 → err = 1, result = 0 one cycle after accept;
  - n = 1 → result = 0;
  - exp = 0 → result = 1;
  - base = 5000 with n = 3233 and exp = 1 → 1767.
- Abort 50 cycles into an operation → IDLE next cycle, no out_valid; the next request computes correctly.
- Backpressure: hold out_ready low for 20 cycles → out_valid and result stay stable and in_ready stays 0. Also, reset_n pulsed mid-SQUARE → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared encodings and sizing helpers for the modular-exponentiation engine.
package rsa_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_SQUARE = 3'd2,
    ST_MULT   = 3'd3,
    ST_DONE   = 3'd4
  } rsa_state_e;

  localparam int DEF_WIDTH     = 256;
  localparam int DEF_EXP_WIDTH = 256;

  // Two guard bits: intermediates of one Blakley step stay below 3n.
  function automatic int rsa_dp_width(input int w);
    return w + 2;
  endfunction
endpackage

// File: rtl/rsa_mod_mul_serial.sv
// Bit-serial MSB-first Blakley modular multiplier: p = a*b mod n, requires b < n.
module rsa_mod_mul_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int DW = rsa_dp_width(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  logic [DW-1:0]    acc_q, acc_d, b_q, b_d, n_q, n_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d;
  logic [DW-1:0]    sum, sub1, sub2;

  always_comb begin
    sum  = {acc_q[DW-2:0], 1'b0} + (a_q[WIDTH-1] ? b_q : '0);
    sub1 = (sum >= n_q) ? sum - n_q : sum;
    sub2 = (sub1 >= n_q) ? sub1 - n_q : sub1;
  end

  always_comb begin
    acc_d  = acc_q;
    b_d    = b_q;
    n_d    = n_q;
    a_d    = a_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b0;
    end else if (start) begin
      a_d   = a;
      b_d   = {2'b00, b};
      n_d   = {2'b00, n};
      acc_d = '0;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = sub2;
      a_d   = a_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      b_q    <= '0;
      n_q    <= '0;
      a_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      b_q    <= b_d;
      n_q    <= n_d;
      a_q    <= a_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q[WIDTH-1:0];
endmodule

// File: rtl/rsa_mod_exp_engine.sv
// Left-to-right square-and-multiply modular exponentiation around one shared serial multiplier.
module rsa_mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
  parameter bit CONST_TIME = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     n,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic                 busy
);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  rsa_state_e           state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d, n_q, n_d, base_r_q, base_r_d;
  logic [WIDTH-1:0]     acc_q, acc_d, result_q, result_d, acc_nx;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 err_q, err_d, launched_q, launched_d, adv;
  logic                 op_st, mul_start, mul_clear, mul_done;
  logic [WIDTH-1:0]     mul_a, mul_b, mul_p;

  assign op_st     = (state_q == ST_REDUCE) || (state_q == ST_SQUARE) || (state_q == ST_MULT);
  assign mul_start = op_st && !launched_q && !abort;
  assign mul_clear = op_st && abort;

  always_comb begin
    mul_a = acc_q;
    mul_b = acc_q;
    case (state_q)
      ST_REDUCE: begin mul_a = base_q;   mul_b = WIDTH'(1); end
      ST_MULT:   begin mul_a = base_r_q; mul_b = acc_q;     end
      default:   ;
    endcase
  end

  rsa_mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .reset_n(reset_n), .start(mul_start), .clear(mul_clear),
    .a(mul_a), .b(mul_b), .n(n_q), .done(mul_done), .p(mul_p)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    n_d        = n_q;
    base_r_d   = base_r_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    result_d   = result_q;
    err_d      = err_q;
    launched_d = launched_q;
    acc_nx     = acc_q;
    adv        = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        base_d   = base;
        exp_d    = exp;
        n_d      = n;
        idx_d    = IW'(EXP_WIDTH - 1);
        result_d = '0;
        if (n == '0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          err_d   = 1'b0;
          acc_d   = (n == WIDTH'(1)) ? '0 : WIDTH'(1);
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE, ST_SQUARE, ST_MULT: begin
        if (abort) begin
          state_d    = ST_IDLE;
          launched_d = 1'b0;
        end else begin
          if (mul_start) launched_d = 1'b1;
          if (mul_done) begin
            launched_d = 1'b0;
            if (state_q == ST_REDUCE) begin
              base_r_d = mul_p;
              state_d  = ST_SQUARE;
            end else if (state_q == ST_SQUARE) begin
              if (exp_q[idx_q] || CONST_TIME) begin
                acc_d   = mul_p;
                state_d = ST_MULT;
              end else begin
                acc_nx = mul_p;
                adv    = 1'b1;
              end
            end else begin
              // Constant-time mode still multiplies on zero bits, but drops the product.
              acc_nx = exp_q[idx_q] ? mul_p : acc_q;
              adv    = 1'b1;
            end
          end
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      acc_d = acc_nx;
      if (idx_q == '0) begin
        result_d = acc_nx;
        state_d  = ST_DONE;
      end else begin
        idx_d   = idx_q - 1'b1;
        state_d = ST_SQUARE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      n_q        <= '0;
      base_r_q   <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      launched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      n_q        <= n_d;
      base_r_q   <= base_r_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      err_q      <= err_d;
      launched_q <= launched_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = op_st;
  assign result    = result_q;
  assign err       = err_q;
endmodule

// File: tb/tb_rsa_mod_exp_engine.sv
// Table-driven and scoreboarded checks of rsa_mod_exp_engine at WIDTH = EXP_WIDTH = 16.
module tb_rsa_mod_exp_engine;
  localparam int W  = 16;
  localparam int EW = 16;
  localparam int M  = W + 2;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, abort = 1'b0;
  logic          in_valid_ct = 1'b0, out_ready_ct = 1'b0;
  logic [W-1:0]  base = '0, n = '0;
  logic [EW-1:0] exp_v = '0;
  logic          in_ready, out_valid, err, busy;
  logic          in_ready_ct, out_valid_ct, err_ct, busy_ct;
  logic [W-1:0]  result, result_ct;

  always #5 clk = ~clk;

  rsa_mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW), .CONST_TIME(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .base(base), .exp(exp_v), .n(n), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .err(err), .busy(busy)
  );

  rsa_mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW), .CONST_TIME(1'b1)) dut_ct (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_ct), .in_ready(in_ready_ct),
    .base(base), .exp(exp_v), .n(n), .abort(abort), .out_valid(out_valid_ct),
    .out_ready(out_ready_ct), .result(result_ct), .err(err_ct), .busy(busy_ct)
  );

  typedef struct { logic [W-1:0] b; logic [EW-1:0] e; logic [W-1:0] n; logic [W-1:0] res; logic er; } vec_t;
  typedef struct { logic [W-1:0] res; logic er; int lat; } sb_t;

  sb_t sbq[$];
  int  nvec = 0, nbad = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    nvec++;
    if (act != req) begin
      nbad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // Cycles from the accept edge until out_valid is seen; n == 0 enters DONE on the accept edge.
  function automatic int lat_of(input logic [EW-1:0] e, input logic [W-1:0] nn, input bit ct);
    if (nn == '0) return 0;
    return M * (1 + EW + (ct ? EW : $countones(e)));
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] nn);
    longint r, bb, m;
    if (nn == '0) return '0;
    m  = longint'(nn);
    bb = longint'(b) % m;
    r  = 1 % m;
    for (int i = EW - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * bb) % m;
    end
    return W'(r);
  endfunction

  task automatic send(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] nn);
    int g = 0;
    while (!in_ready && g < 2000) begin @(negedge clk); g++; end
    chk("in_ready_before_send", in_ready, 1);
    @(negedge clk);
    base = b; exp_v = e; n = nn; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input string nm);
    int c = 0;
    sb_t x;
    while (!out_valid && c < 2000) begin @(posedge clk); #1; c++; end
    chk({nm, "_out_valid"}, out_valid, 1);
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, sbq.size(), 1);
    end else begin
      x = sbq.pop_front();
      chk({nm, "_result"}, result, x.res);
      chk({nm, "_err"}, err, x.er);
      chk({nm, "_latency"}, c, x.lat);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic run_ct(input string nm, input logic [EW-1:0] e);
    int c = 0;
    @(negedge clk);
    base = 16'd65; exp_v = e; n = 16'd3233; in_valid_ct = 1'b1;
    @(posedge clk);
    #1 in_valid_ct = 1'b0;
    while (!out_valid_ct && c < 2000) begin @(posedge clk); #1; c++; end
    chk({nm, "_result"}, result_ct, model(16'd65, e, 16'd3233));
    chk({nm, "_latency"}, c, lat_of(e, 16'd3233, 1'b1));
    out_ready_ct = 1'b1;
    @(posedge clk);
    #1 out_ready_ct = 1'b0;
  endtask

  initial begin
    vec_t vt[7];
    logic [W-1:0] held;
    int hi;
    vt[0] = '{16'd4,    16'd13,   16'd497,  16'd445,  1'b0};
    vt[1] = '{16'd65,   16'd17,   16'd3233, 16'd2790, 1'b0};
    vt[2] = '{16'd2790, 16'd2753, 16'd3233, 16'd65,   1'b0};
    vt[3] = '{16'd7,    16'd3,    16'd0,    16'd0,    1'b1};
    vt[4] = '{16'd9,    16'd5,    16'd1,    16'd0,    1'b0};
    vt[5] = '{16'd123,  16'd0,    16'd3233, 16'd1,    1'b0};
    vt[6] = '{16'd5000, 16'd1,    16'd3233, 16'd1767, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_err", err, 0);
    chk("reset_busy", busy, 0);

    foreach (vt[i]) begin
      send(vt[i].b, vt[i].e, vt[i].n);
      sbq.push_back('{vt[i].res, vt[i].er, lat_of(vt[i].e, vt[i].n, 1'b0)});
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] rb, rn;
      logic [EW-1:0] re;
      rb = W'($urandom); re = EW'($urandom); rn = W'($urandom_range(2, 65535));
      send(rb, re, rn);
      sbq.push_back('{model(rb, re, rn), 1'b0, lat_of(re, rn, 1'b0)});
      collect($sformatf("rnd%0d", i));
    end

    // Abort mid-operation, then confirm the engine recovers.
    send(16'd65, 16'd17, 16'd3233);
    repeat (50) @(posedge clk);
    #1 chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle", {busy, in_ready, out_valid}, 3'b010);
    hi = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) hi++; end
    chk("abort_no_out_valid", hi, 0);
    send(16'd4, 16'd13, 16'd497);
    sbq.push_back('{16'd445, 1'b0, lat_of(16'd13, 16'd497, 1'b0)});
    collect("after_abort");

    // Backpressure: result held, new operands ignored.
    send(16'd4, 16'd13, 16'd497);
    hi = 0;
    while (!out_valid && hi < 2000) begin @(posedge clk); #1; hi++; end
    chk("bp_out_valid", out_valid, 1);
    held = result;
    chk("bp_result", held, 445);
    @(negedge clk);
    base = 16'd9; exp_v = 16'd9; n = 16'd11; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {out_valid, in_ready, result}, {2'b10, held});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_released", {out_valid, in_ready}, 2'b01);

    // out_ready already high: one cycle in DONE.
    out_ready = 1'b1;
    send(16'd65, 16'd17, 16'd3233);
    hi = 0;
    while (!out_valid && hi < 2000) begin @(posedge clk); #1; hi++; end
    chk("early_ready_latency", hi, 342);
    chk("early_ready_result", result, 2790);
    @(posedge clk);
    #1 chk("early_ready_one_cycle", {out_valid, in_ready}, 2'b01);
    out_ready = 1'b0;

    // Reset asserted in SQUARE clears outputs without waiting for a clock edge.
    send(16'd4, 16'd13, 16'd497);
    repeat (25) @(posedge clk);
    #1 chk("rst_busy_before", busy, 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async", {in_ready, out_valid, busy, err, result}, {3'b100, 1'b0, 16'd0});
    @(negedge clk) reset_n = 1'b1;
    send(16'd2790, 16'd2753, 16'd3233);
    sbq.push_back('{16'd65, 1'b0, lat_of(16'd2753, 16'd3233, 1'b0)});
    collect("after_reset");

    run_ct("ct_e17", 16'd17);
    run_ct("ct_e2753", 16'd2753);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
